// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared UART enums and width constants for the tx/rx family.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam int UART_MAX_DATA_BITS = 9;
    localparam int UART_BIT_CTR_W     = $clog2(UART_MAX_DATA_BITS);

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_tx_fifo_if
// Brief     : valid/ready word handshake into the UART transmitter buffer.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Show-ahead synchronous FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [DATA_W-1:0]          din,
    output logic      [DATA_W-1:0]          dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH+1)-1:0] fill
);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;
    logic                w_push;
    logic                w_pop;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_fill == c_FILL_W'(DEPTH));
    assign empty = (r_fill == '0);
    assign fill  = r_fill;
endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered UART transmitter, LSB first, optional parity, 1-2 stops.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  wire logic                               clk,
    input  wire logic                               rst_n,
    uart_tx_fifo_if.slave                           in_if,
    input  wire logic [DIV_WIDTH-1:0]               div,
    output logic                                    tx,
    output logic                                    busy,
    output logic      [$clog2(FIFO_DEPTH+1)-1:0]    fill
);
    localparam parity_e c_PARITY = parity_e'(PARITY);
    localparam logic [UART_BIT_CTR_W-1:0] c_LAST_DATA = UART_BIT_CTR_W'(DATA_BITS - 1);
    localparam logic [UART_BIT_CTR_W-1:0] c_LAST_STOP = UART_BIT_CTR_W'(STOP_BITS - 1);

    tx_state_e                 r_state;
    logic [DATA_BITS-1:0]      r_shift;
    logic                      r_par;
    logic [DIV_WIDTH-1:0]      r_div_q;
    logic [DIV_WIDTH-1:0]      r_baud;
    logic [UART_BIT_CTR_W-1:0] r_bit_ctr;
    logic                      r_tx;
    logic                      r_ready_en;

    logic                      w_bit_end;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic [DATA_BITS-1:0]      w_head;

    assign w_bit_end = (r_baud == r_div_q);
    // Pop either from idle or on the last edge of the final stop bit, so frames chain with no gap.
    assign w_pop = !w_empty &&
                   ((r_state == TX_IDLE) ||
                    ((r_state == TX_STOP) && w_bit_end && (r_bit_ctr == c_LAST_STOP)));

    assign in_if.in_ready = r_ready_en && !w_full;
    assign w_push         = in_if.in_valid && in_if.in_ready;

    sync_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_if.in_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .fill  (fill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= TX_IDLE;
            r_tx       <= 1'b1;
            r_ready_en <= 1'b0;
            r_baud     <= '0;
            r_bit_ctr  <= '0;
            r_div_q    <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_pop) begin
                r_shift <= w_head;
                r_div_q <= div;
                r_par   <= (c_PARITY == PAR_ODD) ? ~^w_head : ^w_head;
            end
            if (r_state == TX_IDLE || w_bit_end) r_baud <= '0;
            else                                 r_baud <= r_baud + DIV_WIDTH'(1);

            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) r_state <= TX_START;
                end
                TX_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_state   <= TX_DATA;
                        r_bit_ctr <= '0;
                    end
                end
                TX_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_ctr == c_LAST_DATA) begin
                            r_bit_ctr <= '0;
                            r_state   <= (c_PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                        end else begin
                            r_bit_ctr <= r_bit_ctr + UART_BIT_CTR_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    r_tx <= r_par;
                    if (w_bit_end) begin
                        r_state   <= TX_STOP;
                        r_bit_ctr <= '0;
                    end
                end
                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (r_bit_ctr == c_LAST_STOP) begin
                            r_bit_ctr <= '0;
                            r_state   <= w_pop ? TX_START : TX_IDLE;
                        end else begin
                            r_bit_ctr <= r_bit_ctr + UART_BIT_CTR_W'(1);
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != TX_IDLE) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Three-configuration bench; tx traces decoded against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int MAXC = 8192;
    localparam int DB  [3] = '{8, 8, 5};
    localparam int SB  [3] = '{1, 2, 1};
    localparam int PAR [3] = '{0, 1, 2};

    logic            clk;
    logic            rst_n;
    logic [15:0]     div;
    logic [7:0]      in_data;
    logic            in_valid;
    logic [2:0]      tx_v;
    logic [2:0]      busy_v;
    logic [2:0]      rdy_v;
    logic [2:0][2:0] fill_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic tx_tr   [3][MAXC];
    logic busy_tr [3][MAXC];
    int   div_tr  [MAXC];

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(5)) if_c ();

    assign if_a.in_data  = in_data;
    assign if_b.in_data  = in_data;
    assign if_c.in_data  = in_data[4:0];
    assign if_a.in_valid = in_valid;
    assign if_b.in_valid = in_valid;
    assign if_c.in_valid = in_valid;
    assign rdy_v = {if_c.in_ready, if_b.in_ready, if_a.in_ready};

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_if(if_a), .div(div),
        .tx(tx_v[0]), .busy(busy_v[0]), .fill(fill_v[0]));
    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(if_b), .div(div),
        .tx(tx_v[1]), .busy(busy_v[1]), .fill(fill_v[1]));
    uart_tx_fifo #(.DATA_BITS(5), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_if(if_c), .div(div),
        .tx(tx_v[2]), .busy(busy_v[2]), .fill(fill_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Index e holds the value seen just after edge e; div_tr[e] is what edge e+1 samples.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            for (int d = 0; d < 3; d++) begin
                tx_tr[d][cyc]   = tx_v[d];
                busy_tr[d][cyc] = busy_v[d];
            end
            div_tr[cyc] = int'(div);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_bits(input int d);
        return 1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + SB[d];
    endfunction

    function automatic logic exp_bit(input int d, input logic [7:0] w, input int b);
        int ones;
        logic [7:0] m;
        m = w & 8'((1 << DB[d]) - 1);
        if (b == 0) return 1'b0;
        if (b <= DB[d]) return m[b-1];
        if (PAR[d] != 0 && b == DB[d] + 1) begin
            ones = $countones(m);
            return (PAR[d] == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    // Push words on consecutive edges; k is the edge taking the first word.
    task automatic push_words(input logic [7:0] w [$], output int k);
        k = cyc + 1;
        foreach (w[i]) begin
            in_data  = w[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Frames of a burst pushed from idle: first start bit at k+2, then back-to-back.
    task automatic check_frames(input int d, input int k, input logic [7:0] w [$], input string tag);
        int s, p, nb, idx;
        logic obs, e;
        s = k + 2;
        check($sformatf("%s_d%0d_pre_start", tag, d), tx_tr[d][s-1], 1'b1);
        check($sformatf("%s_d%0d_busy_at_push", tag, d), busy_tr[d][k], 1'b1);
        foreach (w[i]) begin
            p  = div_tr[s-2] + 1;
            nb = frame_bits(d);
            for (int b = 0; b < nb; b++) begin
                e   = exp_bit(d, w[i], b);
                obs = tx_tr[d][s + b*p];
                for (int j = 0; j < p; j++) begin
                    idx = s + b*p + j;
                    if (idx >= MAXC) obs = 1'bx;
                    else if (tx_tr[d][idx] !== e) obs = tx_tr[d][idx];
                end
                check($sformatf("%s_d%0d_w%0d_bit%0d", tag, d, i, b), obs, e);
            end
            s = s + nb*p;
        end
        check($sformatf("%s_d%0d_idle_after", tag, d), tx_tr[d][s], 1'b1);
        check($sformatf("%s_d%0d_busy_last", tag, d), busy_tr[d][s-2], 1'b1);
        check($sformatf("%s_d%0d_busy_drop", tag, d), busy_tr[d][s-1], 1'b0);
    endtask

    initial begin
        logic [7:0] w [$];
        int k, nw, wt, tchg, re;
        logic ok;

        rst_n = 1'b0; div = 16'd3; in_data = 8'h00; in_valid = 1'b0;
        wait_cycles(3);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_tx_d%0d", d), tx_v[d], 1'b1);
            check($sformatf("rst_busy_d%0d", d), busy_v[d], 1'b0);
            check($sformatf("rst_fill_d%0d", d), fill_v[d], 3'd0);
            check($sformatf("rst_ready_d%0d", d), rdy_v[d], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", rdy_v, 3'b000);
        tick();
        check("ready_after_release", rdy_v, 3'b111);

        // Single 0xA5 at div=3.
        w = '{8'hA5};
        push_words(w, k);
        wait_cycles(60);
        for (int d = 0; d < 3; d++) check_frames(d, k, w, "a5");

        // Parity sample with three ones.
        div = 16'd1;
        w = '{8'h07};
        push_words(w, k);
        wait_cycles(35);
        for (int d = 0; d < 3; d++) check_frames(d, k, w, "par07");

        // Fill to full at div=0; sixth word must stall.
        div = 16'd0;
        w = '{};
        for (int i = 0; i < 6; i++) w.push_back(8'($urandom));
        k = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            in_data = w[i]; in_valid = 1'b1;
            tick();
            for (int d = 0; d < 3; d++)
                check($sformatf("full_fill_d%0d_e%0d", d, i), fill_v[d], (i == 0) ? 3'd1 : 3'(i > 4 ? 4 : i));
            if (i >= 4) check($sformatf("full_ready_e%0d", i), rdy_v, 3'b000);
        end
        in_valid = 1'b0;
        wait_cycles(5);
        check("full_hold_a", fill_v[0], 3'd4);
        tick();
        check("full_pop_fill_a", fill_v[0], 3'd3);
        check("full_pop_ready_a", rdy_v[0], 1'b1);
        void'(w.pop_back());
        wait_cycles(70);
        for (int d = 0; d < 3; d++) begin
            check_frames(d, k, w, "full");
            check($sformatf("full_end_fill_d%0d", d), fill_v[d], 3'd0);
        end

        // Divisor change in the middle of a frame.
        div = 16'd9;
        w = '{8'h3C, 8'hC3};
        push_words(w, k);
        wait_cycles(58);
        div = 16'd1;
        wait_cycles(160);
        check("divchg_first_period", div_tr[k], 9);
        for (int d = 0; d < 3; d++) check_frames(d, k, w, "divchg");

        // Random bursts with random divisors, changed at random times.
        for (int r = 0; r < 8; r++) begin
            nw  = $urandom_range(1, 4);
            div = 16'($urandom_range(0, 3));
            w   = '{};
            for (int i = 0; i < nw; i++) w.push_back(8'($urandom));
            push_words(w, k);
            wt   = nw * 12 * 4 + 12;
            tchg = $urandom_range(0, wt - 1);
            for (int t = 0; t < wt; t++) begin
                if (t == tchg) div = 16'($urandom_range(0, 3));
                tick();
            end
            for (int d = 0; d < 3; d++) check_frames(d, k, w, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a frame with three words queued.
        div = 16'd2;
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_words(w, k);
        wait_cycles(4);
        for (int d = 0; d < 3; d++) check($sformatf("mid_fill_d%0d", d), fill_v[d], 3'd3);
        rst_n = 1'b0;
        tick();
        re = cyc;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("mid_rst_tx_d%0d", d), tx_v[d], 1'b1);
            check($sformatf("mid_rst_fill_d%0d", d), fill_v[d], 3'd0);
            check($sformatf("mid_rst_busy_d%0d", d), busy_v[d], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("mid_ready_held", rdy_v, 3'b000);
        tick();
        check("mid_ready_back", rdy_v, 3'b111);
        wait_cycles(120);
        for (int d = 0; d < 3; d++) begin
            ok = 1'b1;
            for (int e = re; e < re + 120; e++)
                if (tx_tr[d][e] !== 1'b1 || busy_tr[d][e] !== 1'b0) ok = 1'b0;
            check($sformatf("mid_quiet_d%0d", d), ok, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
